// File: rtl/uart_tx_frame_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int OVRSMPL_DEF = 16;
  localparam int W_DATA_MAX  = 9;

  // Even parity is the XOR of the word; odd parity is its complement.
  // Narrower words are zero-extended, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [W_DATA_MAX-1:0] data, input logic odd);
    return odd ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Valid/ready word handshake between the Tx FIFO read side and the transmitter.
interface uart_tx_frame_if #(
  parameter int W_DATA = 8
);
  logic              tx_valid;
  logic [W_DATA-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_frame_baud_gen.sv
// Baud tick generator: one tick every dvsr+1 clk cycles, held at zero while clr.
// Shared with the receiver, so it knows nothing about frames.
module uart_baud_gen #(
  parameter int W_DVSR = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [W_DVSR-1:0] dvsr,
  output logic              tick
);
  logic [W_DVSR-1:0] cnt;

  // Count 0..dvsr and wrap; clr parks the counter so the first tick is a full period away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clr || cnt == dvsr)  cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign tick = !clr && (cnt == dvsr);
endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
//
//  state  | meaning
//  IDLE   | line high, ready for a word
//  START  | driving the start bit (low)
//  DATA   | shifting out data bits, LSB first
//  PARITY | driving the parity bit latched at acceptance
//  STOP   | line high for N_STOP bit times; done pulse on the last tick
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int W_DATA     = 8,
  parameter int W_DVSR     = 16,
  parameter int OVRSMPL    = OVRSMPL_DEF,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int N_STOP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_DVSR-1:0] dvsr,
  uart_tx_frame_if.slave    tx,
  output logic              tx_dout,
  output logic              tx_busy,
  output logic              tx_done_tick
);
  localparam int STOP_TICKS = N_STOP * OVRSMPL;
  localparam int W_TICK     = $clog2(STOP_TICKS + 1);
  localparam int W_BIT      = $clog2(W_DATA);
  localparam logic [W_TICK-1:0] BIT_LAST  = W_TICK'(OVRSMPL - 1);
  localparam logic [W_TICK-1:0] STOP_LAST = W_TICK'(STOP_TICKS - 1);
  localparam logic [W_BIT-1:0]  DATA_LAST = W_BIT'(W_DATA - 1);

  tx_state_t         state, state_n;
  logic [W_DATA-1:0] shreg, shreg_n;
  logic [W_BIT-1:0]  bit_cnt, bit_cnt_n;
  logic [W_TICK-1:0] tick_cnt, tick_cnt_n, tick_last;
  logic [W_DVSR-1:0] dvsr_reg, dvsr_n;
  logic              parity_reg, parity_n;
  logic              dout_reg, dout_n;
  logic              tick, bit_end, ready;

  uart_baud_gen #(.W_DVSR(W_DVSR)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .dvsr (dvsr_reg),
    .tick (tick)
  );

  // State and datapath registers; the line output is registered so it cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      tick_cnt   <= '0;
      dvsr_reg   <= '0;
      parity_reg <= 1'b0;
      dout_reg   <= 1'b1;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      tick_cnt   <= tick_cnt_n;
      dvsr_reg   <= dvsr_n;
      parity_reg <= parity_n;
      dout_reg   <= dout_n;
    end
  end

  // Next-state, bit timing and the line level for the coming cycle.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    tick_cnt_n   = tick_cnt;
    dvsr_n       = dvsr_reg;
    parity_n     = parity_reg;
    tx_done_tick = 1'b0;
    bit_end      = 1'b0;
    dout_n       = 1'b1;
    // STOP spans all stop bits in one count so the done pulse lands on its final tick.
    tick_last    = (state == STOP) ? STOP_LAST : BIT_LAST;

    if (tick) begin
      if (tick_cnt == tick_last) begin
        tick_cnt_n = '0;
        bit_end    = 1'b1;
      end else begin
        tick_cnt_n = tick_cnt + 1'b1;
      end
    end

    unique case (state)
      IDLE: begin
        if (tx.tx_valid) begin
          state_n    = START;
          shreg_n    = tx.tx_data;
          dvsr_n     = dvsr;
          parity_n   = calc_parity(W_DATA_MAX'(tx.tx_data), PARITY_ODD != 0);
          bit_cnt_n  = '0;
          tick_cnt_n = '0;
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) state_n = PARITY;
            else                state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_n      = IDLE;
          tx_done_tick = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      START:   dout_n = 1'b0;
      DATA:    dout_n = shreg_n[0];
      PARITY:  dout_n = parity_n;
      default: dout_n = 1'b1;
    endcase
  end

  assign ready       = (state == IDLE);
  assign tx.tx_ready = ready;
  assign tx_busy     = !ready;
  assign tx_dout     = dout_reg;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (even/1-stop and odd/2-stop), waveform
// compared cycle by cycle against a frame built from the word with plain arithmetic.
module tb_uart_tx_frame;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dvsr_a = '0, dvsr_b = '0;
  logic        dout_a, busy_a, done_a, dout_b, busy_b, done_b;
  logic        sel = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  uart_tx_frame_if #(.W_DATA(8)) if_a ();
  uart_tx_frame_if #(.W_DATA(8)) if_b ();

  uart_tx_frame #(.W_DATA(8), .W_DVSR(16), .OVRSMPL(16), .PARITY_EN(1), .PARITY_ODD(0), .N_STOP(1)) dut_a (
    .clk(clk), .rst(rst), .dvsr(dvsr_a), .tx(if_a),
    .tx_dout(dout_a), .tx_busy(busy_a), .tx_done_tick(done_a));

  uart_tx_frame #(.W_DATA(8), .W_DVSR(16), .OVRSMPL(16), .PARITY_EN(1), .PARITY_ODD(1), .N_STOP(2)) dut_b (
    .clk(clk), .rst(rst), .dvsr(dvsr_b), .tx(if_b),
    .tx_dout(dout_b), .tx_busy(busy_b), .tx_done_tick(done_b));

  wire obs_dout  = sel ? dout_b : dout_a;
  wire obs_busy  = sel ? busy_b : busy_a;
  wire obs_done  = sel ? done_b : done_a;
  wire obs_ready = sel ? if_b.tx_ready : if_a.tx_ready;

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) if_b.tx_valid = v; else if_a.tx_valid = v;
  endtask

  task automatic set_dvsr(input int dv);
    if (sel) dvsr_b = 16'(dv); else dvsr_a = 16'(dv);
  endtask

  task automatic drive(input logic [7:0] d, input int dv);
    if (sel) if_b.tx_data = d; else if_a.tx_data = d;
    set_dvsr(dv);
    set_valid(1'b1);
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge of the idle cycle after the frame.
  task automatic run_frame(input logic [7:0] word, input int dv, input bit keep_valid,
                           input int chg_at, input int dv_new, input string tag);
    int   bit_clks, total, ones, errs, done_cnt, done_at, busy_cnt, n_stop;
    logic exp_bits[$];
    bit_clks = 16 * (dv + 1);
    n_stop   = sel ? 2 : 1;
    exp_bits = {};
    ones     = 0;
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      exp_bits.push_back(word[k]);
      ones += int'(word[k]);
    end
    exp_bits.push_back(sel ? ((ones % 2) == 0) : ((ones % 2) == 1));
    for (int k = 0; k < n_stop; k++) exp_bits.push_back(1'b1);
    total    = exp_bits.size() * bit_clks;
    errs     = 0;
    done_cnt = 0;
    done_at  = -1;
    busy_cnt = 0;

    check(obs_ready, 1, {tag, " ready_before"});
    drive(word, dv);
    @(posedge clk);
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == 0 && !keep_valid) set_valid(1'b0);
      if (i == chg_at) set_dvsr(dv_new);
      if (obs_dout !== exp_bits[i / bit_clks]) errs++;
      if (obs_done === 1'b1) begin done_cnt++; done_at = i; end
      if (obs_busy === 1'b1) busy_cnt++;
      if ((i % bit_clks) == bit_clks - 1) begin
        check(errs, 0, $sformatf("%s bit%0d_bad_cycles", tag, i / bit_clks));
        errs = 0;
      end
    end
    check(done_cnt, 1, {tag, " done_count"});
    check(done_at, total - 1, {tag, " done_cycle"});
    check(busy_cnt, total, {tag, " busy_cycles"});
    @(negedge clk);
    check(obs_ready, 1, {tag, " ready_after"});
    check(obs_dout, 1, {tag, " idle_dout"});
    check(obs_done, 0, {tag, " done_after"});
  endtask

  initial begin
    logic [7:0] w;
    int         dv;
    if_a.tx_valid = 1'b0; if_a.tx_data = '0;
    if_b.tx_valid = 1'b0; if_b.tx_data = '0;

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    check(dout_a, 1, "rst dout_a");
    check(busy_a, 0, "rst busy_a");
    check(done_a, 0, "rst done_a");
    check(dout_b, 1, "rst dout_b");
    check(busy_b, 0, "rst busy_b");
    rst = 1'b0;
    @(negedge clk);
    check(if_a.tx_ready, 1, "rst ready_a");
    check(if_b.tx_ready, 1, "rst ready_b");

    // 0xA5, dvsr=260: 4176-clk bits, 11 bits, parity 0
    sel = 1'b0;
    run_frame(8'hA5, 260, 1'b0, -1, 0, "a5_slow");

    // Random words with random divisors and idle gaps
    for (int n = 0; n < 6; n++) begin
      w  = 8'($urandom);
      dv = int'($urandom_range(0, 3));
      run_frame(w, dv, 1'b0, -1, 0, $sformatf("rand%0d_%02h", n, w));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Back-to-back with valid held high, dvsr=0: one idle cycle between frames
    for (int n = 0; n < 6; n++) begin
      w = 8'($urandom);
      run_frame(w, 0, 1'b1, -1, 0, $sformatf("b2b%0d_%02h", n, w));
    end
    set_valid(1'b0);
    @(negedge clk);

    // Reset in the middle of the data bits of 0x3C
    drive(8'h3C, 1);
    @(posedge clk);
    @(negedge clk);
    set_valid(1'b0);
    repeat (32 * 3 + 10) @(negedge clk);
    check(busy_a, 1, "midrst busy_before");
    #2 rst = 1'b1;
    #1;
    check(dout_a, 1, "midrst dout_now");
    check(busy_a, 0, "midrst busy_now");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check(if_a.tx_ready, 1, "midrst ready_after");
    run_frame(8'h81, 1, 1'b0, -1, 0, "after_rst_81");

    // dvsr changed mid-frame: current frame keeps the latched divisor
    run_frame(8'h6B, 40, 1'b0, 3000, 10, "dvsr40_chg");
    run_frame(8'h94, 10, 1'b0, -1, 0, "dvsr10_next");

    // Odd parity, two stop bits, word 0x00 -> parity bit 1
    sel = 1'b1;
    run_frame(8'h00, 2, 1'b0, -1, 0, "odd2stop_00");
    run_frame(8'h5E, 0, 1'b0, -1, 0, "odd2stop_5e");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
